// File: rtl/hwpe_stream_split_scheduler_if.sv
// Valid/ready stream bundle. A beat transfers on a rising edge where valid && ready are both high;
// the source holds valid/data/strb stable until then and never lets valid depend on ready.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                      valid;
  logic                      ready;
  logic [DATA_WIDTH-1:0]     data;
  logic [DATA_WIDTH/8-1:0]   strb;

  modport source (output valid, output data, output strb, input  ready);
  modport sink   (input  valid, input  data, input  strb, output ready);
  modport master (output valid, output data, output strb, input  ready);
  modport slave  (input  valid, input  data, input  strb, output ready);

endinterface

// File: rtl/hwpe_stream_split_scheduler.sv
// Splits one wide input stream into NB_OUT_STREAMS narrow streams, delivering each beat exactly once
// to every enabled output. Optional beat counter: define HWPE_STREAM_SPLIT_SCHED_STATS_EN.
module hwpe_stream_split_scheduler #(
  parameter int unsigned NB_OUT_STREAMS = 2,
  parameter int unsigned DATA_WIDTH_IN  = 128
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clear_i,
  input  logic [NB_OUT_STREAMS-1:0] enable_mask_i,
  hwpe_stream_intf_stream.sink      push_i,
  hwpe_stream_intf_stream.source    pop_o [NB_OUT_STREAMS-1:0],
`ifdef HWPE_STREAM_SPLIT_SCHED_STATS_EN
  output logic [31:0]               beat_cnt_o,
`endif
  output logic                      o_dbg_state,
  output logic [NB_OUT_STREAMS-1:0] o_dbg_done
);

  localparam int unsigned DW_OUT = DATA_WIDTH_IN / NB_OUT_STREAMS;
  localparam int unsigned SW_OUT = DW_OUT / 8;

  typedef enum logic {
    IDLE    = 1'b0,
    PARTIAL = 1'b1
  } state_t;

  logic [NB_OUT_STREAMS-1:0] r_done;
  logic [NB_OUT_STREAMS-1:0] r_mask;
  logic [NB_OUT_STREAMS-1:0] w_mask_eff;
  logic [NB_OUT_STREAMS-1:0] w_pop_valid;
  logic [NB_OUT_STREAMS-1:0] w_pop_ready;
  logic [NB_OUT_STREAMS-1:0] w_pop_hs;
  state_t                    w_state;
  logic                      w_push_ready;
  logic                      w_push_hs;

  // The state is nothing more than "has any output already taken the current beat".
  assign w_state    = (r_done == '0) ? IDLE : PARTIAL;
  assign w_mask_eff = (w_state == IDLE) ? enable_mask_i : r_mask;

  for (genvar i = 0; i < NB_OUT_STREAMS; i++) begin : g_out
    assign w_pop_valid[i] = push_i.valid & w_mask_eff[i] & ~r_done[i];
    assign pop_o[i].valid = w_pop_valid[i];
    assign pop_o[i].data  = push_i.data[i*DW_OUT +: DW_OUT];
    assign pop_o[i].strb  = push_i.strb[i*SW_OUT +: SW_OUT];
    assign w_pop_ready[i] = pop_o[i].ready;
    assign w_pop_hs[i]    = w_pop_valid[i] & w_pop_ready[i];
  end

  // Input is released once every enabled output has taken, or is taking, the beat.
  assign w_push_ready = &(r_done | w_pop_ready | ~w_mask_eff);
  assign push_i.ready = w_push_ready;
  assign w_push_hs    = push_i.valid & w_push_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_done <= '0;
      r_mask <= '0;
    end else if (clear_i) begin
      r_done <= '0;
      r_mask <= '0;
    end else begin
      if (w_state == IDLE) begin
        r_mask <= enable_mask_i;
      end
      if (w_push_hs) begin
        r_done <= '0;
      end else begin
        r_done <= r_done | w_pop_hs;
      end
    end
  end

`ifdef HWPE_STREAM_SPLIT_SCHED_STATS_EN
  logic [31:0] r_beat_cnt;

  // Dropped beats (empty effective mask) still count as consumed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_beat_cnt <= '0;
    end else if (clear_i) begin
      r_beat_cnt <= '0;
    end else if (w_push_hs) begin
      r_beat_cnt <= r_beat_cnt + 32'd1;
    end
  end

  assign beat_cnt_o = r_beat_cnt;
`endif

  assign o_dbg_state = w_state;
  assign o_dbg_done  = r_done;

endmodule
